// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter slice.
// Pure declarations; no logic, no latency, no flow control.
package counter_pkg;

  localparam bit DIR_UP   = 1'b1;
  localparam bit DIR_DOWN = 1'b0;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/updown_counter_if.sv
// Control and status bundle between a counter and whoever drives it.
// Signals only; no latency, no backpressure (count is presented every cycle).
interface updown_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             overflow;
  logic             underflow;

  modport master (
    output en, up, load, load_value,
    input  count, tc, overflow, underflow
  );

  modport slave (
    input  en, up, load, load_value,
    output count, tc, overflow, underflow
  );

endinterface

// File: rtl/counter_step.sv
// Next-count and wrap-pulse computation for the up/down counter.
// Purely combinational; zero latency, no backpressure.
module counter_step
  import counter_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1,
  parameter int               SATURATE = 0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] next_count,
  output logic             next_overflow,
  output logic             next_underflow
);

  always_comb begin
    next_count     = count;
    next_overflow  = 1'b0;
    next_underflow = 1'b0;
    if (load) begin
      // Out-of-range loads clamp to the top of the range rather than truncating.
      next_count = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else if (en) begin
      if (up == DIR_UP) begin
        if (count >= MAX_VAL) begin
          next_overflow = 1'b1;
          next_count    = (SATURATE != 0) ? MAX_VAL : '0;
        end else begin
          next_count = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          next_underflow = 1'b1;
          next_count     = (SATURATE != 0) ? '0 : MAX_VAL;
        end else begin
          next_count = count - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter over 0..MAX_COUNT with load, wrap or saturate, and wrap pulses.
// One-clock step latency; no backpressure, tc is combinational from count and up.
module updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH     = DEFAULT_WIDTH,
  parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE  = 0
) (
  input logic             clk,
  input logic             reset,
  updown_counter_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 32 || MAX_COUNT < 64'd1 ||
      MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_params
    $fatal(1, "updown_counter: illegal WIDTH=%0d / MAX_COUNT=%0d", WIDTH, MAX_COUNT);
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic [WIDTH-1:0] next_count;
  logic             next_overflow;
  logic             next_underflow;

  counter_step #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_W),
    .SATURATE (SATURATE)
  ) u_step (
    .count          (count_q),
    .en             (bus.en),
    .up             (bus.up),
    .load           (bus.load),
    .load_value     (bus.load_value),
    .next_count     (next_count),
    .next_overflow  (next_overflow),
    .next_underflow (next_underflow)
  );

  // Reset outranks load and en, and also swallows any wrap pulse due this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= next_count;
      overflow_q  <= next_overflow;
      underflow_q <= next_underflow;
    end
  end

  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.tc        = (bus.up == DIR_UP) ? (count_q == MAX_W) : (count_q == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for three counter configurations with a queue-based scoreboard.
module tb_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a [3];
  logic       en_a  [3];
  logic       up_a  [3];
  logic       ld_a  [3];
  logic [3:0] lv_a  [3];
  logic [3:0] cnt_a [3];
  logic       tc_a  [3];
  logic       ovf_a [3];
  logic       unf_a [3];

  updown_counter_if #(.WIDTH(4)) if0 ();
  updown_counter_if #(.WIDTH(4)) if1 ();
  updown_counter_if #(.WIDTH(4)) if2 ();

  // dut 0: 0..15 wrap, dut 1: 0..9 wrap, dut 2: 0..9 saturate
  updown_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(0)) u0 (.clk(clk), .reset(rst_a[0]), .bus(if0.slave));
  updown_counter #(.WIDTH(4), .MAX_COUNT(9),  .SATURATE(0)) u1 (.clk(clk), .reset(rst_a[1]), .bus(if1.slave));
  updown_counter #(.WIDTH(4), .MAX_COUNT(9),  .SATURATE(1)) u2 (.clk(clk), .reset(rst_a[2]), .bus(if2.slave));

  assign if0.en = en_a[0]; assign if0.up = up_a[0]; assign if0.load = ld_a[0]; assign if0.load_value = lv_a[0];
  assign if1.en = en_a[1]; assign if1.up = up_a[1]; assign if1.load = ld_a[1]; assign if1.load_value = lv_a[1];
  assign if2.en = en_a[2]; assign if2.up = up_a[2]; assign if2.load = ld_a[2]; assign if2.load_value = lv_a[2];
  assign cnt_a[0] = if0.count; assign tc_a[0] = if0.tc; assign ovf_a[0] = if0.overflow; assign unf_a[0] = if0.underflow;
  assign cnt_a[1] = if1.count; assign tc_a[1] = if1.tc; assign ovf_a[1] = if1.overflow; assign unf_a[1] = if1.underflow;
  assign cnt_a[2] = if2.count; assign tc_a[2] = if2.tc; assign ovf_a[2] = if2.overflow; assign unf_a[2] = if2.underflow;

  typedef struct packed {
    logic [1:0]  d;
    logic [3:0]  c;
    logic        t;
    logic        o;
    logic        u;
    logic [15:0] id;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;

  // Inputs change 4 time units after the edge; the expectation describes the
  // outputs seen just after the following edge, with up still at the same value.
  task automatic step(input int d, input bit r, input bit ld, input logic [3:0] lv,
                      input bit e, input bit u, input logic [3:0] ec,
                      input bit et, input bit eo, input bit eu);
    exp_t x;
    @(posedge clk);
    #4;
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b0;
      ld_a[i]  = 1'b0;
      en_a[i]  = 1'b0;
    end
    rst_a[d] = r;
    ld_a[d]  = ld;
    lv_a[d]  = lv;
    en_a[d]  = e;
    up_a[d]  = u;
    x.d  = 2'(d);
    x.c  = ec;
    x.t  = et;
    x.o  = eo;
    x.u  = eu;
    x.id = 16'(step_id);
    sb.push_back(x);
    step_id++;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        total++;
        if (cnt_a[x.d] !== x.c) begin
          bad++;
          $display("FAIL count step=%0d dut=%0d got=%0d want=%0d", x.id, x.d, cnt_a[x.d], x.c);
        end
        total++;
        if (tc_a[x.d] !== x.t) begin
          bad++;
          $display("FAIL tc step=%0d dut=%0d got=%b want=%b", x.id, x.d, tc_a[x.d], x.t);
        end
        total++;
        if (ovf_a[x.d] !== x.o) begin
          bad++;
          $display("FAIL overflow step=%0d dut=%0d got=%b want=%b", x.id, x.d, ovf_a[x.d], x.o);
        end
        total++;
        if (unf_a[x.d] !== x.u) begin
          bad++;
          $display("FAIL underflow step=%0d dut=%0d got=%b want=%b", x.id, x.d, unf_a[x.d], x.u);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    bad++;
    $display("FAIL watchdog time limit reached, pending=%0d want=0", sb.size());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stim
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b0; en_a[i] = 1'b0; up_a[i] = 1'b0; ld_a[i] = 1'b0; lv_a[i] = 4'd0;
    end

    // 0..15 wrap: reset, then 17 up-steps
    step(0, 1, 0, 4'd0, 0, 1, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 15; i++)
      step(0, 0, 0, 4'd0, 1, 1, 4'(i), (i == 15), 0, 0);
    step(0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 1, 0);
    step(0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, 0);
    // direction change with no idle cycle, then underflow wrap, then back up
    step(0, 0, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0);
    step(0, 0, 0, 4'd0, 1, 0, 4'd15, 0, 0, 1);
    step(0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 1, 0);
    step(0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, 0);

    // 0..9 wrap: down from reset
    step(1, 1, 0, 4'd0, 0, 0, 4'd0, 1, 0, 0);
    step(1, 0, 0, 4'd0, 1, 0, 4'd9, 0, 0, 1);
    step(1, 0, 0, 4'd0, 1, 0, 4'd8, 0, 0, 0);
    // load clamps and ignores en
    step(1, 0, 1, 4'd12, 1, 1, 4'd9, 1, 0, 0);
    // load 5 then hold with up toggling
    step(1, 0, 1, 4'd5, 0, 1, 4'd5, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 4'd0, 0, (i % 2 == 0) ? 1'b0 : 1'b1, 4'd5, 0, 0, 0);
    // reset on the same edge as an up-step at 9
    step(1, 0, 1, 4'd9, 0, 1, 4'd9, 1, 0, 0);
    step(1, 1, 0, 4'd0, 1, 1, 4'd0, 0, 0, 0);
    // a load right after a wrap clears the pulse
    step(1, 0, 1, 4'd9, 0, 1, 4'd9, 1, 0, 0);
    step(1, 0, 0, 4'd0, 1, 1, 4'd0, 0, 1, 0);
    step(1, 0, 1, 4'd3, 1, 1, 4'd3, 0, 0, 0);
    step(1, 0, 1, 4'd0, 0, 0, 4'd0, 1, 0, 0);

    // 0..9 saturate
    step(2, 1, 0, 4'd0, 0, 1, 4'd0, 0, 0, 0);
    step(2, 0, 1, 4'd8, 0, 1, 4'd8, 0, 0, 0);
    step(2, 0, 0, 4'd0, 1, 1, 4'd9, 1, 0, 0);
    step(2, 0, 0, 4'd0, 1, 1, 4'd9, 1, 1, 0);
    step(2, 0, 0, 4'd0, 1, 1, 4'd9, 1, 1, 0);
    step(2, 0, 0, 4'd0, 0, 1, 4'd9, 1, 0, 0);
    step(2, 0, 1, 4'd0, 0, 0, 4'd0, 1, 0, 0);
    step(2, 0, 0, 4'd0, 1, 0, 4'd0, 1, 0, 1);
    step(2, 0, 0, 4'd0, 0, 0, 4'd0, 1, 0, 0);
    step(2, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, 0);

    @(posedge clk); #4;
    for (int i = 0; i < 3; i++) begin
      en_a[i] = 1'b0; ld_a[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
